mult_div_unit: RTL and testbench

//  Iterative 32-bit multiply/divide unit with HI/LO result registers. Sits directly downstream of the

---
 rtl/multdiv_pkg.sv | 20 ++
 rtl/multdiv_iter_step.sv | 45 ++++
 rtl/mult_div_unit.sv | 166 ++++++++++++++++
 tb/tb_mult_div_unit.sv | 331 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/multdiv_pkg.sv
// Shared definitions for the iterative multiply/divide unit: default operand
// width, Op encodings as they arrive from the decoder, and FSM state encoding.
package multdiv_pkg;

  localparam int MD_WIDTH = 32;

  typedef enum logic [1:0] {
    OP_MULTU = 2'b00,
    OP_DIVU  = 2'b01,
    OP_MULT  = 2'b10,
    OP_DIV   = 2'b11
  } op_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_CALC = 2'b01,
    ST_FIX  = 2'b10
  } state_t;

endpackage

// File: rtl/multdiv_iter_step.sv
// One combinational iteration of the multiply/divide datapath.
// Ports:
//   i_is_div   1      0 = shift-add multiply step, 1 = restoring divide step
//   i_acc      2*W    accumulator before the step
//   i_operand  W      multiplicand (multiply) or divisor (divide)
//   o_acc      2*W    accumulator after the step
// Multiply: acc = {partial, multiplier}; add multiplicand to the upper half when
// acc[0] is set, then shift the whole thing right (carry enters at the top).
// Divide: acc = {remainder, dividend/quotient}; shift left, trial-subtract the
// divisor from the upper bits, keep the difference and set the quotient bit
// when it does not borrow.
module multdiv_iter_step #(
  parameter int WIDTH = 32
) (
  input  logic               i_is_div,
  input  logic [2*WIDTH-1:0] i_acc,
  input  logic [WIDTH-1:0]   i_operand,
  output logic [2*WIDTH-1:0] o_acc
);

  logic [WIDTH:0] w_sum;
  logic [WIDTH:0] w_shift_hi;
  logic [WIDTH:0] w_trial;

  always_comb begin
    w_sum      = {1'b0, i_acc[2*WIDTH-1:WIDTH]}
               + {1'b0, (i_acc[0] ? i_operand : {WIDTH{1'b0}})};
    // Upper half after a left shift, keeping the bit that falls off the top.
    w_shift_hi = i_acc[2*WIDTH-1:WIDTH-1];
    // Remainder stays below the divisor, so the shifted value is under twice
    // the divisor and bit WIDTH of the difference is a reliable borrow flag.
    // With a zero divisor both branches leave the same upper bits.
    w_trial    = w_shift_hi - {1'b0, i_operand};
    if (i_is_div) begin
      if (!w_trial[WIDTH]) begin
        o_acc = {w_trial[WIDTH-1:0], i_acc[WIDTH-2:0], 1'b1};
      end else begin
        o_acc = {i_acc[2*WIDTH-2:0], 1'b0};
      end
    end else begin
      o_acc = {w_sum, i_acc[WIDTH-1:1]};
    end
  end

endmodule

// File: rtl/mult_div_unit.sv
// Iterative multiply/divide unit with HI/LO result registers, one bit per cycle.
// Ports:
//   Clk, Reset (async, active high)
//   Start, Op[1:0] (00 MULTU, 01 DIVU, 10 MULT, 11 DIV), OperandA (rs), OperandB (rt)
//   MtHi, MtLo, MtData      MTHI/MTLO writes, honoured only while idle
//   Busy, Done, DivByZero   status; Done/DivByZero pulse for one cycle
//   Hi, Lo                  product high/low, or remainder/quotient
// Build option: define MULTDIV_SIGNED_EN to make Op 10/11 signed; otherwise
// Op[1] is ignored and no abs/negate logic is built.
//
// state   | meaning
// IDLE    | waiting for Start; MTHI/MTLO writes accepted
// CALC    | WIDTH iterations through multdiv_iter_step
// FIX     | sign fixup, Hi/Lo update, Done pulse
module mult_div_unit
  import multdiv_pkg::*;
#(
  parameter int WIDTH = MD_WIDTH
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             Start,
  input  logic [1:0]       Op,
  input  logic [WIDTH-1:0] OperandA,
  input  logic [WIDTH-1:0] OperandB,
  input  logic             MtHi,
  input  logic             MtLo,
  input  logic [WIDTH-1:0] MtData,
  output logic             Busy,
  output logic             Done,
  output logic             DivByZero,
  output logic [WIDTH-1:0] Hi,
  output logic [WIDTH-1:0] Lo
);

  localparam int DW = 2 * WIDTH;
  localparam int CW = $clog2(WIDTH);

  state_t           r_state;
  logic [CW-1:0]    r_cnt;
  logic [DW-1:0]    r_acc;
  logic [WIDTH-1:0] r_opnd;
  logic [WIDTH-1:0] r_hi;
  logic [WIDTH-1:0] r_lo;
  logic             r_is_div;
  logic             r_dbz_pend;
  logic             r_busy;
  logic             r_done;
  logic             r_dbz;

  logic             w_is_div;
  logic [WIDTH-1:0] w_a_mag;
  logic [WIDTH-1:0] w_b_mag;
  logic [DW-1:0]    w_acc_next;
  logic [WIDTH-1:0] w_res_hi;
  logic [WIDTH-1:0] w_res_lo;

  assign w_is_div = Op[0];

`ifdef MULTDIV_SIGNED_EN
  logic r_neg_res;
  logic r_neg_rem;
  logic w_a_neg;
  logic w_b_neg;

  assign w_a_neg = Op[1] & OperandA[WIDTH-1];
  assign w_b_neg = Op[1] & OperandB[WIDTH-1];
  assign w_a_mag = w_a_neg ? (~OperandA + WIDTH'(1)) : OperandA;
  assign w_b_mag = w_b_neg ? (~OperandB + WIDTH'(1)) : OperandB;
`else
  logic w_unused_op1;

  assign w_unused_op1 = Op[1];
  assign w_a_mag      = OperandA;
  assign w_b_mag      = OperandB;
`endif

  multdiv_iter_step #(
    .WIDTH(WIDTH)
  ) u_step (
    .i_is_div (r_is_div),
    .i_acc    (r_acc),
    .i_operand(r_opnd),
    .o_acc    (w_acc_next)
  );

  // Divide by zero leaves |dividend| in the remainder, so the normal
  // remainder sign fix hands back OperandA unchanged; only Lo is forced.
  always_comb begin
    w_res_hi = r_acc[DW-1:WIDTH];
    w_res_lo = r_acc[WIDTH-1:0];
`ifdef MULTDIV_SIGNED_EN
    if (!r_is_div) begin
      if (r_neg_res) {w_res_hi, w_res_lo} = ~r_acc + DW'(1);
    end else begin
      if (r_neg_rem) w_res_hi = ~r_acc[DW-1:WIDTH] + WIDTH'(1);
      if (r_neg_res) w_res_lo = ~r_acc[WIDTH-1:0] + WIDTH'(1);
    end
`endif
    if (r_dbz_pend) w_res_lo = '1;
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_state    <= ST_IDLE;
      r_cnt      <= '0;
      r_acc      <= '0;
      r_opnd     <= '0;
      r_hi       <= '0;
      r_lo       <= '0;
      r_is_div   <= 1'b0;
      r_dbz_pend <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_dbz      <= 1'b0;
`ifdef MULTDIV_SIGNED_EN
      r_neg_res  <= 1'b0;
      r_neg_rem  <= 1'b0;
`endif
    end else begin
      r_done <= 1'b0;
      r_dbz  <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (Start) begin
            r_is_div   <= w_is_div;
            r_dbz_pend <= w_is_div && (OperandB == '0);
            r_opnd     <= w_is_div ? w_b_mag : w_a_mag;
            r_acc      <= {{WIDTH{1'b0}}, (w_is_div ? w_a_mag : w_b_mag)};
            r_cnt      <= CW'(WIDTH - 1);
            r_busy     <= 1'b1;
            r_state    <= ST_CALC;
`ifdef MULTDIV_SIGNED_EN
            r_neg_res  <= w_a_neg ^ w_b_neg;
            r_neg_rem  <= w_a_neg;
`endif
          end else begin
            if (MtHi) r_hi <= MtData;
            if (MtLo) r_lo <= MtData;
          end
        end
        ST_CALC: begin
          r_acc <= w_acc_next;
          r_cnt <= r_cnt - CW'(1);
          if (r_cnt == '0) r_state <= ST_FIX;
        end
        ST_FIX: begin
          r_hi    <= w_res_hi;
          r_lo    <= w_res_lo;
          r_busy  <= 1'b0;
          r_done  <= 1'b1;
          r_dbz   <= r_dbz_pend;
          r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign Busy      = r_busy;
  assign Done      = r_done;
  assign DivByZero = r_dbz;
  assign Hi        = r_hi;
  assign Lo        = r_lo;

endmodule

// File: tb/tb_mult_div_unit.sv
module tb_mult_div_unit;
  import multdiv_pkg::*;

  logic        Clk;
  logic        Reset;
  logic        Start;
  logic [1:0]  Op;
  logic [31:0] OperandA;
  logic [31:0] OperandB;
  logic        MtHi;
  logic        MtLo;
  logic [31:0] MtData;
  logic        Busy;
  logic        Done;
  logic        DivByZero;
  logic [31:0] Hi;
  logic [31:0] Lo;

  int n_tests = 0;
  int n_fail  = 0;

  mult_div_unit #(.WIDTH(32)) dut (
    .Clk(Clk), .Reset(Reset), .Start(Start), .Op(Op),
    .OperandA(OperandA), .OperandB(OperandB),
    .MtHi(MtHi), .MtLo(MtLo), .MtData(MtData),
    .Busy(Busy), .Done(Done), .DivByZero(DivByZero), .Hi(Hi), .Lo(Lo)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // Reference: plain 64-bit arithmetic. Returns {DivByZero, Hi, Lo}.
  function automatic logic [64:0] model(input logic [1:0] op, input logic [31:0] a,
                                        input logic [31:0] b);
    logic        sgn;
    logic [63:0] p;
    longint      sa, sb, q, r;
`ifdef MULTDIV_SIGNED_EN
    sgn = op[1];
`else
    sgn = 1'b0;
`endif
    if (op[0] == 1'b0) begin
      if (sgn) p = 64'(longint'($signed(a)) * longint'($signed(b)));
      else     p = 64'(a) * 64'(b);
      return {1'b0, p};
    end
    if (b == 32'd0) return {1'b1, a, 32'hFFFF_FFFF};
    if (sgn) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      q  = sa / sb;
      r  = sa % sb;
      return {1'b0, r[31:0], q[31:0]};
    end
    return {1'b0, a % b, a / b};
  endfunction

  function automatic logic [31:0] rnd_operand();
    case ($urandom_range(0, 6))
      0: return 32'd0;
      1: return 32'd1;
      2: return 32'hFFFF_FFFF;
      3: return 32'h8000_0000;
      4: return 32'($urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction

  // Called just after a falling edge. Start is seen at the next rising edge
  // (edge 0); lat is the edge index at which Done was observed, -1 on timeout.
  task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                        input bit disturb,
                        output logic [31:0] hi, output logic [31:0] lo, output logic dbz,
                        output int lat, output logic busy0, output logic stray,
                        output logic [31:0] hi_mid, output logic [31:0] lo_mid);
    Op = op; OperandA = a; OperandB = b; Start = 1'b1;
    @(negedge Clk);
    Start  = 1'b0;
    busy0  = Busy;
    lat    = -1;
    stray  = 1'b0;
    hi_mid = Hi;
    lo_mid = Lo;
    for (int k = 1; k <= 40; k++) begin
      if (disturb && k == 5) begin
        Start = 1'b1; Op = ~op; OperandA = ~a; OperandB = b + 32'd3;
        MtHi = 1'b1; MtLo = 1'b1; MtData = 32'hA5A5_5A5A;
      end
      @(negedge Clk);
      Start = 1'b0; MtHi = 1'b0; MtLo = 1'b0;
      if (k == 20) begin hi_mid = Hi; lo_mid = Lo; end
      if (DivByZero && !Done) stray = 1'b1;
      if (Done) begin lat = k; break; end
    end
    hi = Hi; lo = Lo; dbz = DivByZero;
  endtask

  task automatic test_reset();
    Reset = 1'b1; Start = 1'b0; Op = 2'b00; OperandA = '0; OperandB = '0;
    MtHi = 1'b0; MtLo = 1'b0; MtData = '0;
    #12;
    n_tests++;
    if ({Busy, Done, DivByZero, Hi, Lo} !== 67'd0) begin
      n_fail++;
      $display("FAIL reset_state: got busy=%b done=%b dbz=%b hi=%h lo=%h, expected all zero",
               Busy, Done, DivByZero, Hi, Lo);
    end
    @(negedge Clk);
    Reset = 1'b0;
  endtask

  task automatic test_multu_max();
    logic [31:0] hi, lo, hm, lm; logic dbz, b0, st; int lat;
    run_op(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, hi, lo, dbz, lat, b0, st, hm, lm);
    n_tests++;
    if (b0 !== 1'b1) begin n_fail++; $display("FAIL multu_busy_after_start: got %b expected 1", b0); end
    n_tests++;
    if (lat != 33) begin n_fail++; $display("FAIL multu_latency: got %0d expected 33", lat); end
    n_tests++;
    if ({dbz, hi, lo} !== {1'b0, 64'hFFFF_FFFE_0000_0001}) begin
      n_fail++;
      $display("FAIL multu_max: got dbz=%b hi=%h lo=%h expected 0 fffffffe 00000001", dbz, hi, lo);
    end
    @(negedge Clk);
    n_tests++;
    if ({Done, Busy} !== 2'b00) begin
      n_fail++; $display("FAIL done_one_cycle: got done=%b busy=%b expected 0 0", Done, Busy);
    end
  endtask

  task automatic test_divu();
    logic [31:0] hi, lo, hm, lm; logic dbz, b0, st; int lat;
    run_op(OP_DIVU, 32'd100, 32'd7, 0, hi, lo, dbz, lat, b0, st, hm, lm);
    n_tests++;
    if ({dbz, hi, lo} !== {1'b0, 32'd2, 32'd14}) begin
      n_fail++; $display("FAIL divu_100_7: got dbz=%b hi=%h lo=%h expected 0 2 14", dbz, hi, lo);
    end
    @(negedge Clk);
    run_op(OP_DIVU, 32'd5, 32'd0, 0, hi, lo, dbz, lat, b0, st, hm, lm);
    n_tests++;
    if ({dbz, hi, lo} !== {1'b1, 32'd5, 32'hFFFF_FFFF}) begin
      n_fail++; $display("FAIL divu_by_zero: got dbz=%b hi=%h lo=%h expected 1 5 ffffffff", dbz, hi, lo);
    end
    n_tests++;
    if (st !== 1'b0 || lat != 33) begin
      n_fail++; $display("FAIL dbz_timing: got stray=%b lat=%0d expected 0 33", st, lat);
    end
    @(negedge Clk);
  endtask

  task automatic test_signed();
    logic [31:0] hi, lo, hm, lm; logic dbz, b0, st; int lat;
    logic [63:0] exp_mul, exp_div, exp_min;
`ifdef MULTDIV_SIGNED_EN
    exp_mul = 64'hFFFF_FFFF_FFFF_FFF4;
    exp_div = 64'hFFFF_FFFF_FFFF_FFFD;
    exp_min = 64'h0000_0000_8000_0000;
`else
    exp_mul = 64'h0000_0003_FFFF_FFF4;
    exp_div = 64'h0000_0001_7FFF_FFFC;
    exp_min = 64'h8000_0000_0000_0000;
`endif
    run_op(OP_MULT, 32'hFFFF_FFFD, 32'd4, 0, hi, lo, dbz, lat, b0, st, hm, lm);
    n_tests++;
    if ({hi, lo} !== exp_mul) begin
      n_fail++; $display("FAIL mult_m3_4: got %h%h expected %h", hi, lo, exp_mul);
    end
    @(negedge Clk);
    run_op(OP_DIV, 32'hFFFF_FFF9, 32'd2, 0, hi, lo, dbz, lat, b0, st, hm, lm);
    n_tests++;
    if ({hi, lo} !== exp_div) begin
      n_fail++; $display("FAIL div_m7_2: got %h%h expected %h", hi, lo, exp_div);
    end
    @(negedge Clk);
    run_op(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 0, hi, lo, dbz, lat, b0, st, hm, lm);
    n_tests++;
    if ({dbz, hi, lo} !== {1'b0, exp_min}) begin
      n_fail++; $display("FAIL div_min_m1: got dbz=%b %h%h expected 0 %h", dbz, hi, lo, exp_min);
    end
    @(negedge Clk);
    run_op(OP_DIV, 32'hFFFF_FFF9, 32'd0, 0, hi, lo, dbz, lat, b0, st, hm, lm);
    n_tests++;
    if ({dbz, hi, lo} !== {1'b1, 32'hFFFF_FFF9, 32'hFFFF_FFFF}) begin
      n_fail++; $display("FAIL div_neg_by_zero: got dbz=%b hi=%h lo=%h expected 1 fffffff9 ffffffff",
                         dbz, hi, lo);
    end
    @(negedge Clk);
  endtask

  task automatic test_start_while_busy();
    logic [31:0] hi, lo, hm, lm; logic dbz, b0, st; int lat;
    MtHi = 1'b1; MtLo = 1'b1; MtData = 32'h1111_2222;
    @(negedge Clk);
    MtHi = 1'b0; MtLo = 1'b0;
    run_op(OP_DIVU, 32'd1000, 32'd7, 1, hi, lo, dbz, lat, b0, st, hm, lm);
    n_tests++;
    if ({hm, lm} !== {32'h1111_2222, 32'h1111_2222}) begin
      n_fail++; $display("FAIL mt_while_busy: got hi=%h lo=%h expected 11112222 11112222", hm, lm);
    end
    n_tests++;
    if ({dbz, hi, lo} !== {1'b0, 32'd6, 32'd142} || lat != 33) begin
      n_fail++; $display("FAIL start_while_busy: got hi=%h lo=%h lat=%0d expected 6 142 33", hi, lo, lat);
    end
    @(negedge Clk);
  endtask

  task automatic test_mt();
    int lat;
    MtHi = 1'b1; MtData = 32'h0000_1234;
    @(negedge Clk);
    MtHi = 1'b0;
    n_tests++;
    if (Hi !== 32'h0000_1234) begin n_fail++; $display("FAIL mthi: got %h expected 00001234", Hi); end
    MtHi = 1'b1; MtLo = 1'b1; MtData = 32'hCAFE_F00D;
    @(negedge Clk);
    MtHi = 1'b0; MtLo = 1'b0;
    n_tests++;
    if ({Hi, Lo} !== {32'hCAFE_F00D, 32'hCAFE_F00D}) begin
      n_fail++; $display("FAIL mthi_mtlo: got hi=%h lo=%h expected cafef00d cafef00d", Hi, Lo);
    end
    Op = OP_MULTU; OperandA = 32'd2; OperandB = 32'd3; Start = 1'b1;
    MtLo = 1'b1; MtData = 32'hDEAD_BEEF;
    @(negedge Clk);
    Start = 1'b0; MtLo = 1'b0;
    n_tests++;
    if ({Busy, Lo} !== {1'b1, 32'hCAFE_F00D}) begin
      n_fail++; $display("FAIL start_beats_mt: got busy=%b lo=%h expected 1 cafef00d", Busy, Lo);
    end
    lat = -1;
    for (int k = 1; k <= 40; k++) begin
      @(negedge Clk);
      if (Done) begin lat = k; break; end
    end
    n_tests++;
    if ({Hi, Lo} !== {32'd0, 32'd6} || lat != 33) begin
      n_fail++; $display("FAIL multu_2_3: got hi=%h lo=%h lat=%0d expected 0 6 33", Hi, Lo, lat);
    end
    @(negedge Clk);
  endtask

  task automatic test_back_to_back();
    logic [31:0] hi, lo, hm, lm; logic dbz, b0, st; int lat;
    logic [64:0] exp;
    run_op(OP_MULTU, 32'd12345, 32'd6789, 0, hi, lo, dbz, lat, b0, st, hm, lm);
    exp = model(OP_MULTU, 32'd12345, 32'd6789);
    n_tests++;
    if ({dbz, hi, lo} !== exp) begin
      n_fail++; $display("FAIL b2b_first: got %b %h %h expected %h", dbz, hi, lo, exp);
    end
    // Start driven while Done is high.
    run_op(OP_DIVU, 32'hFFFF_FFFF, 32'd16, 0, hi, lo, dbz, lat, b0, st, hm, lm);
    exp = model(OP_DIVU, 32'hFFFF_FFFF, 32'd16);
    n_tests++;
    if ({dbz, hi, lo} !== exp || lat != 33 || b0 !== 1'b1) begin
      n_fail++; $display("FAIL b2b_second: got %b %h %h lat=%0d busy0=%b expected %h lat=33 busy0=1",
                         dbz, hi, lo, lat, b0, exp);
    end
    @(negedge Clk);
  endtask

  task automatic test_random();
    logic [31:0] hi, lo, hm, lm, a, b; logic dbz, b0, st; int lat;
    logic [1:0]  op;
    logic [64:0] exp;
    for (int i = 0; i < 40; i++) begin
      op  = 2'($urandom_range(0, 3));
      a   = rnd_operand();
      b   = rnd_operand();
      exp = model(op, a, b);
      run_op(op, a, b, 0, hi, lo, dbz, lat, b0, st, hm, lm);
      n_tests++;
      if ({dbz, hi, lo} !== exp || lat != 33 || st !== 1'b0) begin
        n_fail++;
        $display("FAIL random_%0d: op=%0d a=%h b=%h got %b %h %h lat=%0d expected %h lat=33",
                 i, op, a, b, dbz, hi, lo, lat, exp);
      end
      if (i % 3 == 0) @(negedge Clk);
    end
    @(negedge Clk);
  endtask

  task automatic test_reset_mid_op();
    logic [31:0] hi, lo, hm, lm; logic dbz, b0, st; int lat;
    bit seen_done;
    MtHi = 1'b1; MtLo = 1'b1; MtData = 32'h7777_8888;
    @(negedge Clk);
    MtHi = 1'b0; MtLo = 1'b0;
    Op = OP_MULTU; OperandA = 32'd99; OperandB = 32'd77; Start = 1'b1;
    @(negedge Clk);
    Start = 1'b0;
    repeat (10) @(negedge Clk);
    #2 Reset = 1'b1;
    #1;
    n_tests++;
    if ({Busy, Done, Hi, Lo} !== 66'd0) begin
      n_fail++; $display("FAIL reset_abort: got busy=%b done=%b hi=%h lo=%h expected all zero",
                         Busy, Done, Hi, Lo);
    end
    @(negedge Clk);
    Reset = 1'b0;
    seen_done = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge Clk);
      if (Done || Busy) seen_done = 1;
    end
    n_tests++;
    if (seen_done) begin n_fail++; $display("FAIL no_done_after_abort: got activity, expected none"); end
    run_op(OP_DIVU, 32'd9, 32'd3, 0, hi, lo, dbz, lat, b0, st, hm, lm);
    n_tests++;
    if ({dbz, hi, lo} !== {1'b0, 32'd0, 32'd3} || lat != 33) begin
      n_fail++; $display("FAIL divu_9_3: got %b %h %h lat=%0d expected 0 0 3 lat=33", dbz, hi, lo, lat);
    end
    @(negedge Clk);
  endtask

  initial begin
    test_reset();
    test_multu_max();
    test_divu();
    test_signed();
    test_start_while_busy();
    test_mt();
    test_back_to_back();
    test_random();
    test_reset_mid_op();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
